div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the execute stage. It services the four divide-class ALU operations (div, divu, mod, modu) using a radix-2 restoring algorithm with a fixed 32-iteration latency. The execute stage issues an operation, stalls while `busy` is high, and on the `complete` pulse muxes `result` into the ALU result path, which drives the ALU's `complete` output.

## Interface
- No parameters. Data width is fixed at 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  operation request; sampled only in IDLE.
- `div_op`  in  4  one-hot {modu, mod, divu, div}, same order as ALU op bits 18..15.
- `src1`  in  32  dividend (rj).
- `src2`  in  32  divisor (rk).
- `flush`  in  1  cancel any in-flight operation (exception/branch flush).
- `busy`  out  1  high whenever state != IDLE.
- `complete`  out  1  one-cycle pulse; `result` valid this cycle.
- `result`  out  32  quotient or remainder per latched `div_op`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if `start && !flush`, latch `src1`, `src2`, and the op. Derive `is_signed = div|mod` and `want_rem = mod|modu`. Load `|src1|` and `|src2|` (absolute values when signed, raw otherwise), clear the remainder and the 6-bit iteration counter, then go to CALC.
- CALC: one restoring step per cycle:
  - Shift {rem, dividend} left 1.
  - Trial-subtract the divisor from rem (33-bit).
  - If the difference is non-negative, keep it and set quotient bit 1; otherwise keep rem and set bit 0.
  - Counter increments. After the 32nd step, go to DONE.
- DONE: apply sign fix-up, then drive `result`, assert `complete`, and go to IDLE.
- Sign fix-up (signed ops):
  - Quotient is negated iff src1[31] ^ src2[31].
  - Remainder takes the sign of src1.
- Divide by zero (src2 == 0, any signedness). The fix-up is overridden:
  - Quotient = 0xFFFFFFFF.
  - Remainder = original src1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. The unsigned-magnitude datapath produces this naturally; no special case is needed.
- `start` while `busy` is ignored. `start` in the DONE cycle is ignored; the next operation is accepted in IDLE.
- `flush` in CALC or DONE: go to IDLE on the next edge and suppress `complete` (a flush in DONE masks that cycle's pulse combinationally). `flush` and `start` together in IDLE: flush wins and nothing is accepted.
- `div_op` with zero or multiple bits set is not checked. The signed/rem decode above applies as-is.

## Timing
- Reset values: state=IDLE, `busy`=0, `complete`=0, `result`=0, counter=0, all datapath registers 0.
- Fixed latency, no early termination. `start` accepted in cycle N gives:
  - `busy`=1 in cycles N+1..N+33.
  - `complete`=1 only in cycle N+33.
  - `busy`=0 from N+34.
  - The earliest next accept is cycle N+34.
- `result` is registered. It stays stable from the `complete` cycle until the next accepted start loads new operands. It is not cleared by flush.
- `complete` is never high in two consecutive cycles.
- `reset` mid-CALC: outputs go to reset values immediately (asynchronously). The first post-reset `start` is handled normally.
- No combinational path from any input to `busy` or `result`. `complete` depends on `flush` only in DONE.

## Test plan
- div 100/7 -> `result`=14 at N+33; mod 100/7 -> 2; `busy` high for exactly 33 cycles.
- mod src1=0xFFFFFFF9 (-7), src2=2 -> 0xFFFFFFFF (-1); div gives 0xFFFFFFFD (-3); divu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- div 0x80000000/0xFFFFFFFF -> 0x80000000; mod -> 0.
- divu 1234/0 -> 0xFFFFFFFF; modu 1234/0 -> 1234; div 0xFFFFFF00/0 -> 0xFFFFFFFF; mod 0xFFFFFF00/0 -> 0xFFFFFF00.
- Flush at N+10 -> no `complete`, `busy`=0 at N+11; a second `start` at N+5 during busy is ignored; a fresh div 9/3 then completes 33 cycles after its accept with 3.
- Assert `reset` at N+20 for 1 cycle -> `busy`/`complete`/`result`=0 immediately; a subsequent divu 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.

Source files
------------

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake bundle.
// The execute stage drives requests and flush; the divider returns status and result.
interface div_unit_if;
    logic        start;
    logic [3:0]  div_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        busy;
    logic        complete;
    logic [31:0] result;

    modport master (
        output start, div_op, src1, src2, flush,
        input  busy, complete, result
    );

    modport slave (
        input  start, div_op, src1, src2, flush,
        output busy, complete, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for div/divu/mod/modu.
// Operands are reduced to magnitudes on accept, 32 unsigned steps run in CALC,
// and the sign/divide-by-zero fix-up is folded into the result register load
// on the final step so that result is already registered in the DONE cycle.
module div_unit (
    input  logic      clk,
    input  logic      reset,
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [5:0]  cnt_q;
    logic [31:0] dvd_q;        // dividend magnitude, becomes quotient as bits shift in
    logic [31:0] dsr_q;        // divisor magnitude
    logic [31:0] rem_q;        // partial remainder
    logic [31:0] src1_q;       // raw dividend, needed for remainder sign and div-by-zero
    logic        src2_neg_q;
    logic        is_signed_q;
    logic        want_rem_q;
    logic        div_zero_q;
    logic [31:0] result_q;

    logic        op_signed;
    logic        op_rem;
    logic        accept;
    logic        step;
    logic        last_step;
    logic        done_pulse;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] dvd_step;

    // Absolute value for signed ops, pass-through for unsigned ones.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v,
                                              input logic use_sign);
        if (use_sign && (v < 0))
            return $unsigned(-v);
        return $unsigned(v);
    endfunction

    // Turn unsigned quotient/remainder magnitudes into the architectural result.
    function automatic logic [31:0] fix_result(input logic [31:0] q_mag,
                                               input logic [31:0] r_mag,
                                               input logic [31:0] dividend,
                                               input logic        sgn,
                                               input logic        rem_sel,
                                               input logic        divisor_neg,
                                               input logic        by_zero);
        if (by_zero)
            return rem_sel ? dividend : 32'hFFFF_FFFF;
        if (rem_sel)
            return (sgn && dividend[31]) ? (32'd0 - r_mag) : r_mag;
        return (sgn && (dividend[31] ^ divisor_neg)) ? (32'd0 - q_mag) : q_mag;
    endfunction

    assign op_signed = bus.div_op[0] | bus.div_op[2];
    assign op_rem    = bus.div_op[2] | bus.div_op[3];

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign step      = (state == CALC) && !bus.flush;
    assign last_step = step && (cnt_q == 6'd31);

    // One restoring step: shift, trial-subtract, keep difference if it did not borrow.
    always_comb begin
        shifted  = {rem_q, dvd_q[31]};
        trial    = shifted - {1'b0, dsr_q};
        q_bit    = ~trial[32];
        rem_step = q_bit ? trial[31:0] : shifted[31:0];
        dvd_step = {dvd_q[30:0], q_bit};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and the completion pulse; flush masks the pulse in DONE.
    always_comb begin
        state_nxt  = state;
        done_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush)
                    state_nxt = CALC;
            end
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (cnt_q == 6'd31)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt  = IDLE;
                done_pulse = !bus.flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one iteration per CALC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            src1_q      <= '0;
            src2_neg_q  <= 1'b0;
            is_signed_q <= 1'b0;
            want_rem_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else if (accept) begin
            cnt_q       <= '0;
            dvd_q       <= magnitude(bus.src1, op_signed);
            dsr_q       <= magnitude(bus.src2, op_signed);
            rem_q       <= '0;
            src1_q      <= bus.src1;
            src2_neg_q  <= bus.src2[31];
            is_signed_q <= op_signed;
            want_rem_q  <= op_rem;
            div_zero_q  <= (bus.src2 == 32'd0);
        end else if (step) begin
            cnt_q <= cnt_q + 6'd1;
            dvd_q <= dvd_step;
            rem_q <= rem_step;
        end
    end

    // Result is loaded from the final step's outputs so it is valid throughout DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            result_q <= '0;
        else if (last_step)
            result_q <= fix_result(dvd_step, rem_step, src1_q, is_signed_q,
                                   want_rem_q, src2_neg_q, div_zero_q);
    end

    assign bus.busy     = (state != IDLE);
    assign bus.complete = done_pulse;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed operations with literal expected results, plus a
// cycle-window reference model checked against busy/complete/result every cycle.
module tb_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    div_unit_if bus();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: what the operation must return, from plain integer math.
    function automatic logic [31:0] ref_div(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic   sgn;
        logic   rsel;
        longint sa;
        longint sb;
        sgn  = op[0] | op[2];
        rsel = op[2] | op[3];
        if (b == 32'd0)
            return rsel ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return rsel ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rsel ? (a % b) : (a / b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted op occupies cycles N+1..N+33, completes in N+33,
    // and its value appears on result from N+33 onwards unless flushed earlier.
    int          m_cyc = 0;
    int          m_done = 0;
    bit          m_active = 1'b0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_res = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_res    = '0;
        end else begin
            if (m_active) begin
                if (bus.flush)
                    m_active = 1'b0;
                else if (m_cyc == m_done)
                    m_active = 1'b0;
                else if (m_cyc == m_done - 1)
                    m_res = m_exp;
            end else if (bus.start && !bus.flush) begin
                m_active = 1'b1;
                m_done   = m_cyc + 33;
                m_exp    = ref_div(bus.div_op, bus.src1, bus.src2);
            end
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_busy", {31'd0, bus.busy}, {31'd0, m_active});
            chk("mon_complete", {31'd0, bus.complete},
                {31'd0, m_active && (m_cyc == m_done) && !bus.flush});
            chk("mon_result", bus.result, m_res);
        end
    end

    // Issue one op, then check latency, busy length and the literal result.
    task automatic run_op(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        int bcnt;
        bit seen;
        chk({nm, "_model"}, ref_div(op, a, b), exp);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.div_op = op; bus.src1 = a; bus.src2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0; bcnt = 0; lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.complete) begin
                seen = 1'b1;
                lat  = n;
                chk({nm, "_result"}, bus.result, exp);
            end
        end
        chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_latency"}, lat, 33);
        chk({nm, "_busycnt"}, bcnt, 33);
        @(negedge clk);
        chk({nm, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_hold"}, bus.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_c;
        bus.start = 1'b0; bus.div_op = 4'b0000; bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 mon_en = 1'b1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_complete", {31'd0, bus.complete}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op("div_100_7",   4'b0001, 32'd100, 32'd7, 32'd14);
        run_op("mod_100_7",   4'b0100, 32'd100, 32'd7, 32'd2);
        run_op("modu_100_7",  4'b1000, 32'd100, 32'd7, 32'd2);
        run_op("mod_m7_2",    4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_m7_2",    4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("divu_m7_2",   4'b0010, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run_op("div_ovf",     4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("mod_ovf",     4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("divu_by0",    4'b0010, 32'd1234, 32'd0, 32'hFFFF_FFFF);
        run_op("modu_by0",    4'b1000, 32'd1234, 32'd0, 32'd1234);
        run_op("div_by0",     4'b0001, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF);
        run_op("mod_by0",     4'b0100, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00);
        run_op("div_m100_7",  4'b0001, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

        // Flush mid-CALC, with an ignored start while busy.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.div_op = 4'b0001; bus.src1 = 32'd50; bus.src2 = 32'd5;
        @(posedge clk); #1;                          // cycle N+1
        bus.start = 1'b0;
        repeat (4) @(posedge clk); #1;               // cycle N+5
        bus.start = 1'b1; bus.src1 = 32'd77; bus.src2 = 32'd3;
        @(posedge clk); #1;                          // cycle N+6
        bus.start = 1'b0;
        repeat (4) @(posedge clk); #1;               // cycle N+10
        bus.flush = 1'b1;
        @(posedge clk); #1;                          // cycle N+11
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        seen_c = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.complete) seen_c = 1'b1;
        end
        chk("flush_no_complete", {31'd0, seen_c}, 32'd0);
        chk("flush_result_kept", bus.result, 32'hFFFF_FFF2);
        run_op("div_9_3", 4'b0001, 32'd9, 32'd3, 32'd3);

        // Flush in the DONE cycle masks complete but result still updates.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.div_op = 4'b1000; bus.src1 = 32'd100; bus.src2 = 32'd7;
        @(posedge clk); #1;                          // cycle N+1
        bus.start = 1'b0;
        repeat (32) @(posedge clk); #1;              // cycle N+33
        bus.flush = 1'b1;
        @(negedge clk);
        chk("dflush_complete", {31'd0, bus.complete}, 32'd0);
        chk("dflush_busy", {31'd0, bus.busy}, 32'd1);
        chk("dflush_result", bus.result, 32'd2);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("dflush_idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.div_op = 4'b0010; bus.src1 = 32'd77; bus.src2 = 32'd3;
        @(posedge clk); #1;                          // cycle N+1
        bus.start = 1'b0;
        repeat (19) @(posedge clk); #1;              // cycle N+20
        reset = 1'b1;
        #1;
        chk("areset_busy", {31'd0, bus.busy}, 32'd0);
        chk("areset_complete", {31'd0, bus.complete}, 32'd0);
        chk("areset_result", bus.result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("divu_post_rst", 4'b0010, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
